// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the multiplier issue/collect sequencer.
package mult_seq_pkg;

  localparam int unsigned OpWidth   = 8;
  localparam int unsigned ProdWidth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StOut
  } state_e;

  typedef struct packed {
    logic [OpWidth-1:0] a;
    logic [OpWidth-1:0] b;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers and count reset asynchronously, storage is not reset.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AddrWidth = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [AddrWidth-1:0] r_wptr;
  logic [AddrWidth-1:0] r_rptr;
  logic [AddrWidth:0]   r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign o_full    = (r_count == (AddrWidth + 1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Buffers operand pairs, issues them one at a time to a reset-started shift-add multiplier,
// and returns products (or timeout markers) in issue order.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OpWidth-1:0]   in_a,
  input  logic [OpWidth-1:0]   in_b,
  output logic                 mult_rst,
  output logic [OpWidth-1:0]   mult_multiplicand,
  output logic [OpWidth-1:0]   mult_multiplier,
  input  logic [ProdWidth-1:0] mult_result,
  input  logic                 mult_end_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ProdWidth-1:0] out_product,
  output logic                 out_err,
  output logic                 busy
);

  localparam int unsigned     TcntWidth = $clog2(TIMEOUT);
  localparam logic [TcntWidth-1:0] TcntLast = TcntWidth'(TIMEOUT - 1);

  state_e                 r_state;
  logic                   r_mult_rst;
  logic [OpWidth-1:0]     r_multiplicand;
  logic [OpWidth-1:0]     r_multiplier;
  logic                   r_out_valid;
  logic [ProdWidth-1:0]   r_product;
  logic                   r_err;
  logic [TcntWidth-1:0]   r_tcnt;

  entry_t w_wentry;
  entry_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_wentry = '{a: in_a, b: in_b};
  // Pop only when the FSM is about to load operands: from IDLE, or straight out of a handshake.
  assign w_pop    = !w_empty && ((r_state == StIdle) || ((r_state == StOut) && out_ready));

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_wdata(w_wentry),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_mult_rst     <= 1'b1;
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_out_valid    <= 1'b0;
      r_product      <= '0;
      r_err          <= 1'b0;
      r_tcnt         <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_multiplicand <= w_head.a;
            r_multiplier   <= w_head.b;
            r_state        <= StIssue;
          end
        end
        StIssue: begin
          r_mult_rst <= 1'b0;
          r_tcnt     <= '0;
          r_state    <= StWait;
        end
        StWait: begin
          // end_op in the first WAIT cycle may be left over from the previous operation.
          if ((r_tcnt != '0) && mult_end_op) begin
            r_product   <= mult_result;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_mult_rst  <= 1'b1;
            r_tcnt      <= '0;
            r_state     <= StOut;
          end else if (r_tcnt == TcntLast) begin
            r_product   <= '0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_mult_rst  <= 1'b1;
            r_tcnt      <= '0;
            r_state     <= StOut;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (w_pop) begin
              r_multiplicand <= w_head.a;
              r_multiplier   <= w_head.b;
              r_state        <= StIssue;
            end else begin
              r_state <= StIdle;
            end
          end
        end
      endcase
    end
  end

  assign mult_rst          = r_mult_rst;
  assign mult_multiplicand = r_multiplicand;
  assign mult_multiplier   = r_multiplier;
  assign out_valid         = r_out_valid;
  assign out_product       = r_product;
  assign out_err           = r_err;
  assign busy              = (r_state != StIdle) || !w_empty;

endmodule
